// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: ICU instruction encoding and sequencer FSM states.
package program_sequencer_pkg;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [3:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;

  typedef logic [1:0] seq_state_t;
  localparam seq_state_t PRIME = 2'd0;
  localparam seq_state_t RUN   = 2'd1;
  localparam seq_state_t HALT  = 2'd2;

  // Mirrors the ICU's own decision to skip the word that follows.
  function automatic logic sets_skip(input instruction_t op, input logic rr);
    return (op == RTN) || ((op == SKZ) && !rr);
  endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses; dout shows the current top entry, valid only when not empty.
module return_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign wr_idx  = IDX_W'(sp);
  assign dout    = mem[top_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage needs no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// ICU program-control front end: PC, fetch, jump/call/return redirection, skip mirror, halt/resume.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic [PC_W-1:0]        prog_addr,
  input  logic [OPCODE_W+PC_W-1:0] prog_data,
  output logic                   icu_rst,
  output instruction_t           instr,
  output logic [PC_W-1:0]        io_addr,
  input  logic                   icu_jmp,
  input  logic                   icu_rtn,
  input  logic                   icu_flag_o,
  input  logic                   icu_flag_f,
  input  logic                   icu_rr,
  output logic                   halted,
  output logic                   stack_err
);

  localparam int unsigned DATA_W = OPCODE_W + PC_W;

  seq_state_t      state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc;
  logic [PC_W-1:0] operand, stack_top;
  instruction_t    opcode;
  logic            skip, skip_n;
  logic            err_n;
  logic            push, pop, full, empty;

  assign opcode    = instruction_t'(prog_data[DATA_W-1:PC_W]);
  assign operand   = prog_data[PC_W-1:0];
  assign instr     = opcode;
  assign io_addr   = operand;
  assign prog_addr = pc;
  assign pc_inc    = pc + PC_W'(1);

  return_stack #(
    .WIDTH (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc),
    .dout  (stack_top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    icu_rst <= !rst;
    if (!rst) begin
      state     <= PRIME;
      pc        <= '0;
      skip      <= 1'b0;
      stack_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      skip      <= skip_n;
      stack_err <= err_n;
      halted    <= (state_n == HALT);
    end
  end

  // Flags at this edge describe the word currently on prog_data; skipped words are inert.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    skip_n  = skip;
    err_n   = stack_err;
    push    = 1'b0;
    pop     = 1'b0;
    case (state)
      PRIME: state_n = RUN;
      RUN: begin
        if (skip) begin
          skip_n = 1'b0;
          pc_n   = pc_inc;
        end else begin
          skip_n = sets_skip(opcode, icu_rr);
          if (icu_flag_f) begin
            state_n = HALT;
          end else if (icu_jmp) begin
            pc_n = operand;
          end else if (icu_flag_o) begin
            if (full) err_n = 1'b1;
            else      push  = 1'b1;
            pc_n = operand;
          end else if (icu_rtn) begin
            if (empty) begin
              err_n = 1'b1;
              pc_n  = pc_inc;
            end else begin
              pop  = 1'b1;
              pc_n = stack_top;
            end
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      HALT: begin
        if (run) begin
          pc_n    = pc_inc;
          state_n = RUN;
        end
      end
      default: state_n = PRIME;
    endcase
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a ROM and a small behavioural ICU flag model.
module tb_program_sequencer;

  localparam int unsigned PC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run = 1'b0;
  logic [PC_W-1:0] prog_addr;
  logic [PC_W+3:0] prog_data;
  logic            icu_rst;
  logic [3:0]      instr;
  logic [PC_W-1:0] io_addr;
  logic            icu_jmp = 1'b0;
  logic            icu_rtn = 1'b0;
  logic            icu_flag_o = 1'b0;
  logic            icu_flag_f = 1'b0;
  logic            icu_rr = 1'b1;
  logic            icu_skip = 1'b0;
  logic            halted;
  logic            stack_err;

  logic [PC_W+3:0] rom [256];
  int n_tests = 0;
  int n_fail  = 0;

  assign prog_data = rom[prog_addr];

  program_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .icu_rst    (icu_rst),
    .instr      (instr),
    .io_addr    (io_addr),
    .icu_jmp    (icu_jmp),
    .icu_rtn    (icu_rtn),
    .icu_flag_o (icu_flag_o),
    .icu_flag_f (icu_flag_f),
    .icu_rr     (icu_rr),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  // ICU model: latches the presented instruction on the falling edge.
  always @(negedge clk) begin
    if (icu_rst) begin
      {icu_jmp, icu_rtn, icu_flag_o, icu_flag_f, icu_skip} <= 5'b0;
    end else if (icu_skip) begin
      {icu_jmp, icu_rtn, icu_flag_o, icu_flag_f, icu_skip} <= 5'b0;
    end else begin
      icu_jmp    <= (instr == 4'hC);
      icu_rtn    <= (instr == 4'hD);
      icu_flag_o <= (instr == 4'h0);
      icu_flag_f <= (instr == 4'hF);
      icu_skip   <= (instr == 4'hD) || ((instr == 4'hE) && !icu_rr);
    end
  end

  function automatic logic [PC_W+3:0] w(input logic [3:0] op, input logic [PC_W-1:0] a);
    return {op, a};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_default;
    for (int i = 0; i < 256; i++) rom[i] = w(4'h1, 8'h00);
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_reset;
    load_default();
    rom[1] = w(4'h8, 8'h00);
    rom[2] = w(4'h5, 8'h00);
    rom[3] = w(4'hF, 8'h00);
    apply_reset();
    n_tests++; if (prog_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", prog_addr); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", stack_err); end
    n_tests++; if (icu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_icu_rst: got %b want 1", icu_rst); end
    rst = 1'b1;
    step(1);
    n_tests++; if (prog_addr !== 8'h00) begin n_fail++; $display("FAIL prime_addr: got %h want 00", prog_addr); end
    n_tests++; if (icu_rst !== 1'b0) begin n_fail++; $display("FAIL prime_icu_rst: got %b want 0", icu_rst); end
    for (int i = 1; i <= 3; i++) begin
      step(1);
      n_tests++;
      if (prog_addr !== 8'(i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, prog_addr, 8'(i)); end
    end
    step(1);
    n_tests++; if (prog_addr !== 8'h03) begin n_fail++; $display("FAIL halt_addr: got %h want 03", prog_addr); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
    step(1);
    n_tests++; if (prog_addr !== 8'h03 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %h/%b want 03/1", prog_addr, halted); end
  endtask

  task automatic test_jmp;
    load_default();
    rom[5] = w(4'hC, 8'h20);
    apply_reset();
    run = 1'b1;
    rst = 1'b1;
    step(6);
    n_tests++; if (prog_addr !== 8'h05) begin n_fail++; $display("FAIL jmp_pre: got %h want 05", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h20) begin n_fail++; $display("FAIL jmp_target: got %h want 20", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h21) begin n_fail++; $display("FAIL jmp_next: got %h want 21", prog_addr); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL jmp_run_ignored: got %b want 0", halted); end
    run = 1'b0;
  endtask

  task automatic test_wrap;
    load_default();
    rom[0] = w(4'hC, 8'hFF);
    apply_reset();
    rst = 1'b1;
    step(2);
    n_tests++; if (prog_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_top: got %h want ff", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_zero: got %h want 00", prog_addr); end
  endtask

  task automatic test_call_return;
    load_default();
    rom[4]    = w(4'h0, 8'h40);
    rom[8'h40] = w(4'hD, 8'h00);
    apply_reset();
    rst = 1'b1;
    step(5);
    n_tests++; if (prog_addr !== 8'h04) begin n_fail++; $display("FAIL call_pre: got %h want 04", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h40) begin n_fail++; $display("FAIL call_target: got %h want 40", prog_addr); end
    n_tests++; if (dut.u_stack.sp !== 2'd1) begin n_fail++; $display("FAIL call_sp: got %0d want 1", dut.u_stack.sp); end
    step(1);
    n_tests++; if (prog_addr !== 8'h04) begin n_fail++; $display("FAIL rtn_addr: got %h want 04", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h05) begin n_fail++; $display("FAIL rtn_skip: got %h want 05", prog_addr); end
    n_tests++; if (dut.u_stack.sp !== 2'd0) begin n_fail++; $display("FAIL rtn_sp: got %0d want 0", dut.u_stack.sp); end
    step(1);
    n_tests++; if (prog_addr !== 8'h06 || stack_err !== 1'b0) begin n_fail++; $display("FAIL rtn_cont: got %h/%b want 06/0", prog_addr, stack_err); end
  endtask

  task automatic test_skz;
    load_default();
    rom[7] = w(4'hE, 8'h00);
    rom[8] = w(4'hC, 8'h30);
    icu_rr = 1'b0;
    apply_reset();
    rst = 1'b1;
    step(9);
    n_tests++; if (prog_addr !== 8'h08) begin n_fail++; $display("FAIL skz_pre: got %h want 08", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h09) begin n_fail++; $display("FAIL skz_skip: got %h want 09", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h0A) begin n_fail++; $display("FAIL skz_next: got %h want 0a", prog_addr); end
    icu_rr = 1'b1;
  endtask

  task automatic test_stack_limits;
    load_default();
    rom[0]     = w(4'h0, 8'h10);
    rom[8'h10] = w(4'h0, 8'h20);
    rom[8'h20] = w(4'h0, 8'h30);
    rom[8'h30] = w(4'hD, 8'h00);
    apply_reset();
    rst = 1'b1;
    step(3);
    n_tests++; if (prog_addr !== 8'h20 || stack_err !== 1'b0) begin n_fail++; $display("FAIL nest2: got %h/%b want 20/0", prog_addr, stack_err); end
    step(1);
    n_tests++; if (prog_addr !== 8'h30) begin n_fail++; $display("FAIL ovf_target: got %h want 30", prog_addr); end
    n_tests++; if (stack_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", stack_err); end
    step(1);
    n_tests++; if (prog_addr !== 8'h10) begin n_fail++; $display("FAIL ovf_pop: got %h want 10", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h11 || stack_err !== 1'b1) begin n_fail++; $display("FAIL ovf_skip: got %h/%b want 11/1", prog_addr, stack_err); end

    load_default();
    rom[3] = w(4'hD, 8'h00);
    apply_reset();
    n_tests++; if (stack_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", stack_err); end
    rst = 1'b1;
    step(5);
    n_tests++; if (prog_addr !== 8'h04 || stack_err !== 1'b1) begin n_fail++; $display("FAIL udf: got %h/%b want 04/1", prog_addr, stack_err); end
    step(1);
    n_tests++; if (prog_addr !== 8'h05) begin n_fail++; $display("FAIL udf_skip: got %h want 05", prog_addr); end
  endtask

  task automatic test_halt_resume;
    load_default();
    rom[0]     = w(4'hC, 8'h10);
    rom[8'h10] = w(4'hF, 8'h00);
    rom[8'h11] = w(4'h0, 8'h30);
    rom[8'h30] = w(4'hF, 8'h00);
    apply_reset();
    rst = 1'b1;
    step(3);
    n_tests++; if (prog_addr !== 8'h10 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got %h/%b want 10/1", prog_addr, halted); end
    step(2);
    n_tests++; if (prog_addr !== 8'h10 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_stay: got %h/%b want 10/1", prog_addr, halted); end
    run = 1'b1;
    step(1);
    run = 1'b0;
    n_tests++; if (prog_addr !== 8'h11 || halted !== 1'b0) begin n_fail++; $display("FAIL resume: got %h/%b want 11/0", prog_addr, halted); end
    step(2);
    n_tests++; if (prog_addr !== 8'h30 || halted !== 1'b1) begin n_fail++; $display("FAIL call_halt: got %h/%b want 30/1", prog_addr, halted); end
    rst = 1'b0;
    step(1);
    n_tests++; if (prog_addr !== 8'h00 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got %h/%b want 00/0", prog_addr, halted); end
    n_tests++; if (icu_rst !== 1'b1 || dut.u_stack.sp !== 2'd0) begin n_fail++; $display("FAIL halt_reset_icu_sp: got %b/%0d want 1/0", icu_rst, dut.u_stack.sp); end
    rst = 1'b1;
    step(1);
    n_tests++; if (prog_addr !== 8'h00) begin n_fail++; $display("FAIL reprime: got %h want 00", prog_addr); end
    step(1);
    n_tests++; if (prog_addr !== 8'h10) begin n_fail++; $display("FAIL rerun_jmp: got %h want 10", prog_addr); end
  endtask

  initial begin
    test_reset();
    test_jmp();
    test_wrap();
    test_call_return();
    test_skz();
    test_stack_limits();
    test_halt_resume();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
